ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pipe.sv | 185 ++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control path for a 5-stage in-order pipeline. It decodes ID into control bundles, carries them
// through EX/MEM/WB, and resolves memory freeze, load-use stalls and branch/jump flushes.
module ctrl_pipe #(
  parameter int REG_AW           = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int IALU_EN          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              mem_busy,
  input  logic              ex_branch_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              id_jump,
  output logic              id_illegal,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_signext,
  output logic              ex_branch,
  output logic              ex_branchne,
  output logic              ex_jumpr,
  output logic [2:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              mem_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic              wb_link,
  output logic [REG_AW-1:0] wb_wreg
);

  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic              signext;
    logic              branch;
    logic              branchne;
    logic              jumpr;
    logic [2:0]        aluop;
    logic [REG_AW-1:0] wreg;
    logic              mem_read;
    logic              mem_write;
    logic              regwrite;
    logic              memtoreg;
    logic              link;
  } ctrl_t;

  ctrl_t dec, ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic legal, is_jmp, uses_rt, hz_ex, hz_mem, load_use;
  logic [REG_AW-1:0] dest;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    legal     = 1'b1;
    is_jmp    = 1'b0;
    uses_rt   = 1'b0;
    dest      = '0;
    case (opcode)
      6'h00: begin
        if (funct == 6'h08) begin
          dec.jumpr = 1'b1;
          is_jmp    = 1'b1;
        end else begin
          dec.aluop = 3'b010;
          dest      = id_rd;
          uses_rt   = 1'b1;
        end
      end
      6'h23: begin
        dec.alusrc   = 1'b1;
        dec.signext  = 1'b1;
        dec.mem_read = 1'b1;
        dec.memtoreg = 1'b1;
        dest         = id_rt;
      end
      6'h2b: begin
        dec.alusrc    = 1'b1;
        dec.signext   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      6'h04, 6'h05: begin
        dec.aluop    = 3'b001;
        dec.signext  = 1'b1;
        dec.branch   = ~opcode[0];
        dec.branchne = opcode[0];
        uses_rt      = 1'b1;
      end
      6'h02: is_jmp = 1'b1;
      6'h03: begin
        is_jmp   = 1'b1;
        dec.link = 1'b1;
        dest     = REG_AW'(31);
      end
      // addi/addiu sign-extend; the logical ops and lui zero-extend (opcode bit 2 set)
      6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        legal       = (IALU_EN != 0);
        dec.alusrc  = 1'b1;
        dec.signext = ~opcode[2];
        dest        = id_rt;
        case (opcode[2:0])
          3'd4:    dec.aluop = 3'b011;
          3'd5:    dec.aluop = 3'b100;
          3'd6:    dec.aluop = 3'b101;
          3'd7:    dec.aluop = 3'b110;
          default: dec.aluop = 3'b000;
        endcase
      end
      default: legal = 1'b0;
    endcase
    dec.wreg     = dest;
    dec.regwrite = (dest != '0);
    if (!(id_valid && legal)) dec = '0;
  end

  assign id_jump    = id_valid & legal & is_jmp;
  assign id_illegal = id_valid & ~legal;

  assign hz_ex  = ex_q.valid & ex_q.mem_read & (ex_q.wreg != '0) &
                  ((ex_q.wreg == id_rs) | (uses_rt & (ex_q.wreg == id_rt)));
  assign hz_mem = (LOAD_USE_BUBBLES == 2) & mem_q.valid & mem_q.mem_read & (mem_q.wreg != '0) &
                  ((mem_q.wreg == id_rs) | (uses_rt & (mem_q.wreg == id_rt)));
  assign load_use = id_valid & (hz_ex | hz_mem);

  // mem_busy freezes everything and masks flushes; a taken branch overrides load-use
  assign pc_stall   = mem_busy | (~ex_branch_taken & load_use);
  assign ifid_stall = pc_stall;
  assign ifid_flush = ~mem_busy & (ex_branch_taken | (id_jump & ~load_use));

  always_comb begin
    ex_d  = (ex_branch_taken | load_use) ? '0 : dec;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (mem_busy) begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_signext  = ex_q.signext;
  assign ex_branch   = ex_q.branch;
  assign ex_branchne = ex_q.branchne;
  assign ex_jumpr    = ex_q.jumpr;
  assign ex_aluop    = ex_q.aluop;
  assign ex_wreg     = ex_q.wreg;
  assign mem_valid   = mem_q.valid;
  assign mem_read    = mem_q.mem_read;
  assign mem_write   = mem_q.mem_write;
  assign mem_wreg    = mem_q.wreg;
  assign wb_valid    = wb_q.valid;
  assign wb_regwrite = wb_q.regwrite;
  assign wb_memtoreg = wb_q.memtoreg;
  assign wb_link     = wb_q.link;
  assign wb_wreg     = wb_q.wreg;

  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a decode table, directed hazard/freeze/reset sequences and a randomized
// run against a stage-array reference model. Two instances: defaults, and IALU_EN=0/2 bubbles.
module tb_ctrl_pipe;
  logic clk = 0, rst_n;
  logic id_valid, mem_busy, ex_branch_taken;
  logic [5:0] opcode, funct;
  logic [4:0] id_rs, id_rt, id_rd;

  logic pc_stall, ifid_stall, ifid_flush, id_jump, id_illegal, ex_valid, ex_alusrc, ex_signext;
  logic ex_branch, ex_branchne, ex_jumpr, mem_valid, mem_read, mem_write;
  logic wb_valid, wb_regwrite, wb_memtoreg, wb_link;
  logic [2:0] ex_aluop;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic d2_pc_stall, d2_ifid_stall, d2_ifid_flush, d2_id_jump, d2_id_illegal, d2_ex_valid;
  logic d2_ex_alusrc, d2_ex_signext, d2_ex_branch, d2_ex_branchne, d2_ex_jumpr;
  logic d2_mem_valid, d2_mem_read, d2_mem_write, d2_wb_valid, d2_wb_regwrite, d2_wb_memtoreg, d2_wb_link;
  logic [2:0] d2_ex_aluop;
  logic [4:0] d2_ex_wreg, d2_mem_wreg, d2_wb_wreg;

  int ntest = 0, nfail = 0;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .id_jump(id_jump),
    .id_illegal(id_illegal), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_signext(ex_signext),
    .ex_branch(ex_branch), .ex_branchne(ex_branchne), .ex_jumpr(ex_jumpr), .ex_aluop(ex_aluop),
    .ex_wreg(ex_wreg), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wreg(mem_wreg), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_link(wb_link), .wb_wreg(wb_wreg));

  ctrl_pipe #(.REG_AW(5), .LOAD_USE_BUBBLES(2), .IALU_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken),
    .pc_stall(d2_pc_stall), .ifid_stall(d2_ifid_stall), .ifid_flush(d2_ifid_flush), .id_jump(d2_id_jump),
    .id_illegal(d2_id_illegal), .ex_valid(d2_ex_valid), .ex_alusrc(d2_ex_alusrc), .ex_signext(d2_ex_signext),
    .ex_branch(d2_ex_branch), .ex_branchne(d2_ex_branchne), .ex_jumpr(d2_ex_jumpr), .ex_aluop(d2_ex_aluop),
    .ex_wreg(d2_ex_wreg), .mem_valid(d2_mem_valid), .mem_read(d2_mem_read), .mem_write(d2_mem_write),
    .mem_wreg(d2_mem_wreg), .wb_valid(d2_wb_valid), .wb_regwrite(d2_wb_regwrite), .wb_memtoreg(d2_wb_memtoreg),
    .wb_link(d2_wb_link), .wb_wreg(d2_wb_wreg));

  logic [35:0] v1, v2;
  assign v1 = {pc_stall, ifid_stall, ifid_flush, id_jump, id_illegal, ex_valid, ex_alusrc, ex_signext,
               ex_branch, ex_branchne, ex_jumpr, ex_aluop, ex_wreg, mem_valid, mem_read, mem_write,
               mem_wreg, wb_valid, wb_regwrite, wb_memtoreg, wb_link, wb_wreg};
  assign v2 = {d2_pc_stall, d2_ifid_stall, d2_ifid_flush, d2_id_jump, d2_id_illegal, d2_ex_valid,
               d2_ex_alusrc, d2_ex_signext, d2_ex_branch, d2_ex_branchne, d2_ex_jumpr, d2_ex_aluop,
               d2_ex_wreg, d2_mem_valid, d2_mem_read, d2_mem_write, d2_mem_wreg, d2_wb_valid,
               d2_wb_regwrite, d2_wb_memtoreg, d2_wb_link, d2_wb_wreg};

  // reference model: one record per instruction occupying a stage
  typedef struct packed {
    logic v, alusrc, sx, br, brne, jr;
    logic [2:0] aluop;
    logic [4:0] wreg;
    logic mr, mw, rw, m2r, link;
  } mc_t;

  function automatic mc_t mdec(input logic [5:0] op, fn, input logic [4:0] rt, rd,
                               input bit ien, output bit ill, output bit jmp);
    mc_t c;
    logic [4:0] dst;
    c = '0; dst = 0; ill = 0; jmp = 0; c.v = 1;
    if (op == 0 && fn == 8) begin c.jr = 1; jmp = 1; end
    else if (op == 0) begin c.aluop = 2; dst = rd; end
    else if (op == 6'h23) begin c.alusrc = 1; c.sx = 1; c.mr = 1; c.m2r = 1; dst = rt; end
    else if (op == 6'h2b) begin c.alusrc = 1; c.sx = 1; c.mw = 1; end
    else if (op == 4 || op == 5) begin c.aluop = 1; c.sx = 1; c.br = (op == 4); c.brne = (op == 5); end
    else if (op == 2) jmp = 1;
    else if (op == 3) begin jmp = 1; c.link = 1; dst = 31; end
    else if (ien && (op == 8 || op == 9)) begin c.alusrc = 1; c.sx = 1; dst = rt; end
    else if (ien && op >= 6'h0c && op <= 6'h0f) begin c.alusrc = 1; c.aluop = 3'(op - 6'h0c + 6'd3); dst = rt; end
    else ill = 1;
    c.rw = (dst != 0); c.wreg = dst;
    if (ill) c = '0;
    return c;
  endfunction

  function automatic bit ldhaz(mc_t s, logic [4:0] rs, rt, bit urt);
    return s.v && s.mr && s.wreg != 0 && (s.wreg == rs || (urt && s.wreg == rt));
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(bit v, logic [5:0] op, fn, logic [4:0] rs, rt, rd);
    id_valid = v; opcode = op; funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic do_reset();
    rst_n = 0; drive(0, 0, 0, 0, 0, 0); mem_busy = 0; ex_branch_taken = 0;
    tick(); rst_n = 1;
  endtask

  typedef struct {
    logic [5:0] op, fn; logic [4:0] rt, rd;
    bit ill, ill2, jmp; logic [2:0] aluop; bit alusrc, sx, mr, rw; logic [4:0] wreg; bit link;
  } vec_t;
  vec_t tbl[16];

  mc_t st[2][3];
  bit ienv[2] = '{1, 0};
  int lubv[2] = '{1, 2};

  initial begin
    //            op     fn    rt  rd   ill i2 jmp alu src sx mr rw wreg link
    tbl[0]  = '{6'h23, 6'h00, 5, 0,   0, 0, 0, 0, 1, 1, 1, 1, 5,  0};
    tbl[1]  = '{6'h2b, 6'h00, 6, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0};
    tbl[2]  = '{6'h04, 6'h00, 2, 0,   0, 0, 0, 1, 0, 1, 0, 0, 0,  0};
    tbl[3]  = '{6'h05, 6'h00, 2, 0,   0, 0, 0, 1, 0, 1, 0, 0, 0,  0};
    tbl[4]  = '{6'h00, 6'h20, 2, 9,   0, 0, 0, 2, 0, 0, 0, 1, 9,  0};
    tbl[5]  = '{6'h00, 6'h08, 2, 9,   0, 0, 1, 0, 0, 0, 0, 0, 0,  0};
    tbl[6]  = '{6'h03, 6'h00, 2, 0,   0, 0, 1, 0, 0, 0, 0, 1, 31, 1};
    tbl[7]  = '{6'h02, 6'h00, 2, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0,  0};
    tbl[8]  = '{6'h08, 6'h00, 4, 0,   0, 1, 0, 0, 1, 1, 0, 1, 4,  0};
    tbl[9]  = '{6'h0c, 6'h00, 4, 0,   0, 1, 0, 3, 1, 0, 0, 1, 4,  0};
    tbl[10] = '{6'h0d, 6'h00, 0, 0,   0, 1, 0, 4, 1, 0, 0, 0, 0,  0};
    tbl[11] = '{6'h0e, 6'h00, 3, 0,   0, 1, 0, 5, 1, 0, 0, 1, 3,  0};
    tbl[12] = '{6'h0f, 6'h00, 3, 0,   0, 1, 0, 6, 1, 0, 0, 1, 3,  0};
    tbl[13] = '{6'h3f, 6'h00, 3, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0,  0};
    tbl[14] = '{6'h0a, 6'h00, 3, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0,  0};
    tbl[15] = '{6'h09, 6'h00, 7, 0,   0, 1, 0, 0, 1, 1, 0, 1, 7,  0};

    rst_n = 0; drive(0, 0, 0, 0, 0, 0); mem_busy = 0; ex_branch_taken = 0;
    #3;
    chk("reset_state", v1, 36'h0);
    chk("reset_state2", v2, 36'h0);
    mem_busy = 1; #1;
    chk("reset_stall_from_inputs", {pc_stall, ifid_stall, ifid_flush}, 3'b110);
    mem_busy = 0;
    tick(); rst_n = 1;

    // decode table: one instruction followed by bubbles, checked as it walks to WB
    foreach (tbl[i]) begin
      drive(1, tbl[i].op, tbl[i].fn, 1, tbl[i].rt, tbl[i].rd);
      #1;
      chk($sformatf("id_flags[%0d]", i), {id_illegal, id_jump, ifid_flush}, {tbl[i].ill, tbl[i].jmp, tbl[i].jmp});
      chk($sformatf("id_illegal2[%0d]", i), d2_id_illegal, tbl[i].ill2);
      tick(); id_valid = 0;
      chk($sformatf("ex[%0d]", i), {ex_valid, ex_aluop, ex_alusrc, ex_signext},
          {!tbl[i].ill, tbl[i].aluop, tbl[i].alusrc, tbl[i].sx});
      chk($sformatf("ex_valid2[%0d]", i), d2_ex_valid, !tbl[i].ill2);
      tick();
      chk($sformatf("mem[%0d]", i), {mem_valid, mem_read}, {!tbl[i].ill, tbl[i].mr});
      tick();
      chk($sformatf("wb[%0d]", i), {wb_valid, wb_regwrite, wb_link, wb_wreg},
          {!tbl[i].ill, tbl[i].rw, tbl[i].link, tbl[i].wreg});
    end

    // load-use: 1 bubble on dut, 2 on dut2
    do_reset();
    drive(1, 6'h23, 0, 1, 7, 0); tick();
    drive(1, 6'h00, 6'h20, 7, 2, 3); #1;
    chk("lu_stall_c0", {pc_stall, ifid_stall, d2_pc_stall, ex_valid}, 4'b1111);
    tick();
    chk("lu_c1", {ex_valid, pc_stall, d2_ex_valid, d2_pc_stall}, 4'b0001);
    tick();
    chk("lu_c2_add", {ex_valid, ex_aluop, ex_wreg, d2_ex_valid, d2_pc_stall}, {1'b1, 3'd2, 5'd3, 1'b0, 1'b0});
    tick();
    chk("lu_c3_add2", {d2_ex_valid, d2_ex_aluop, d2_ex_wreg}, {1'b1, 3'd2, 5'd3});
    id_valid = 0;

    // taken branch beats load-use
    do_reset();
    drive(1, 6'h23, 0, 1, 7, 0); tick();
    drive(1, 6'h00, 6'h20, 7, 2, 3); ex_branch_taken = 1; #1;
    chk("bt_over_lu", {ifid_flush, pc_stall, ifid_stall}, 3'b100);
    tick(); ex_branch_taken = 0; id_valid = 0;
    chk("bt_bubble", {ex_valid, mem_read}, 2'b01);

    // mem_busy freeze for 3 cycles
    do_reset();
    drive(1, 6'h23, 0, 1, 7, 0); tick();
    drive(1, 6'h00, 6'h20, 8, 9, 10); tick();
    drive(1, 6'h23, 0, 10, 11, 0); mem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("busy_stall[%0d]", k), {pc_stall, ifid_stall, ifid_flush}, 3'b110);
      chk($sformatf("busy_hold[%0d]", k), {ex_valid, ex_aluop, ex_wreg, mem_valid, mem_read, mem_wreg, wb_valid},
          {1'b1, 3'd2, 5'd10, 1'b1, 1'b1, 5'd7, 1'b0});
      tick();
    end
    mem_busy = 0; id_valid = 0; tick();
    chk("busy_resume", {mem_valid, mem_wreg, wb_valid, wb_memtoreg, wb_wreg},
        {1'b1, 5'd10, 1'b1, 1'b1, 5'd7});

    // jal link, then async reset mid-stream
    do_reset();
    drive(1, 6'h03, 0, 1, 2, 0); #1;
    chk("jal_id", {id_jump, ifid_flush}, 2'b11);
    tick(); id_valid = 0; tick(); tick();
    chk("jal_wb", {wb_valid, wb_link, wb_regwrite, wb_wreg}, {1'b1, 1'b1, 1'b1, 5'd31});
    drive(1, 6'h23, 0, 1, 5, 0); tick(); tick();
    rst_n = 0; #1;
    chk("async_rst", {ex_valid, mem_valid, wb_valid, d2_ex_valid, d2_mem_valid, d2_wb_valid}, 6'b0);
    tick(); rst_n = 1;

    // randomized run against the model
    for (int d = 0; d < 2; d++) for (int s = 0; s < 3; s++) st[d][s] = '0;
    begin
      logic [5:0] ops[17] = '{6'h00, 6'h00, 6'h23, 6'h23, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                              6'h03, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h3f};
      logic [5:0] fns[3] = '{6'h20, 6'h08, 6'h22};
      for (int i = 0; i < 800; i++) begin
        mc_t nx[2][3];
        rst_n = ($urandom_range(0, 79) != 0);
        drive($urandom_range(0, 9) != 0, ops[$urandom_range(0, 16)], fns[$urandom_range(0, 2)],
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        mem_busy = ($urandom_range(0, 6) == 0);
        ex_branch_taken = ($urandom_range(0, 9) == 0);
        #1;
        for (int d = 0; d < 2; d++) begin
          mc_t c; bit ill, jmp, lu, urt, ps, fl;
          if (!rst_n) for (int s = 0; s < 3; s++) st[d][s] = '0;
          c = mdec(opcode, funct, id_rt, id_rd, ienv[d], ill, jmp);
          if (!id_valid) begin c = '0; ill = 0; jmp = 0; end
          urt = (opcode == 0 && funct != 8) || opcode == 4 || opcode == 5 || opcode == 6'h2b;
          lu = id_valid && (ldhaz(st[d][0], id_rs, id_rt, urt) ||
                            (lubv[d] == 2 && ldhaz(st[d][1], id_rs, id_rt, urt)));
          ps = mem_busy || (!ex_branch_taken && lu);
          fl = !mem_busy && (ex_branch_taken || (jmp && !lu));
          chk($sformatf("rand%0d[%0d]", d, i), (d == 0) ? v1 : v2,
              {ps, ps, fl, jmp, ill, st[d][0].v, st[d][0].alusrc, st[d][0].sx, st[d][0].br, st[d][0].brne,
               st[d][0].jr, st[d][0].aluop, st[d][0].wreg, st[d][1].v, st[d][1].mr, st[d][1].mw,
               st[d][1].wreg, st[d][2].v, st[d][2].rw, st[d][2].m2r, st[d][2].link, st[d][2].wreg});
          nx[d] = st[d];
          if (!rst_n) for (int s = 0; s < 3; s++) nx[d][s] = '0;
          else if (!mem_busy) begin
            nx[d][2] = st[d][1]; nx[d][1] = st[d][0];
            nx[d][0] = (ex_branch_taken || lu) ? '0 : c;
          end
        end
        tick();
        st = nx;
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
